// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter sharing the single cache request port among NUM_REQ requesters.
// Define CACHE_REQ_ARBITER_PERF_EN to add saturating grant/stall counters.
package cache_pkg;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [3:0] {
        LSU_LB,
        LSU_LH,
        LSU_LW,
        LSU_LBU,
        LSU_LHU,
        LSU_SB,
        LSU_SH,
        LSU_SW
    } lsu_ops;
endpackage

module cache_req_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = cache_pkg::DATA_WIDTH
) (
    input  logic                               clk,
    input  logic                               rst,
`ifdef CACHE_REQ_ARBITER_PERF_EN
    input  logic                               perf_clr,
    output logic [NUM_REQ-1:0][31:0]           grant_cnt,
    output logic [31:0]                        stall_cnt,
`endif
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [ADDR_WIDTH-1:0]              req_addr  [NUM_REQ],
    input  cache_pkg::lsu_ops                  req_op    [NUM_REQ],
    input  logic [31:0]                        req_wdata [NUM_REQ],
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    output logic [DATA_WIDTH-1:0]              rsp_rdata,
    output logic                               busy,
    output logic [ADDR_WIDTH-1:0]              address,
    output cache_pkg::lsu_ops                  lsu_operator,
    output logic [31:0]                        write_data,
    output logic                               mem_enable,
    input  logic                               stall,
    input  logic [DATA_WIDTH-1:0]              read_data
);
    import cache_pkg::*;

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]      owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    lsu_ops                op_q, op_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  found;
    logic [PTR_W-1:0]      win;
    logic                  complete;
    int                    idx;

    // Scan upward from rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
    end

    assign complete = (state_q == ISSUE) && !stall;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        op_d     = op_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d = win;
                    addr_d  = req_addr[win];
                    op_d    = req_op[win];
                    wdata_d = req_wdata[win];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (complete) begin
                    rdata_d  = read_data;
                    rr_ptr_d = (owner_q == LAST) ? '0 : owner_q + 1'b1;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            addr_q   <= '0;
            op_q     <= LSU_LB;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            op_q     <= op_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (state_q == IDLE && found) req_ready = NUM_REQ'(1) << win;
        if (state_q == DONE) rsp_valid = NUM_REQ'(1) << owner_q;
    end

    assign mem_enable   = (state_q == ISSUE);
    assign busy         = (state_q != IDLE);
    assign address      = addr_q;
    assign lsu_operator = op_q;
    assign write_data   = wdata_q;
    assign rsp_rdata    = rdata_q;

`ifdef CACHE_REQ_ARBITER_PERF_EN
    logic [NUM_REQ-1:0][31:0] grant_cnt_q, grant_cnt_d;
    logic [31:0]              stall_cnt_q, stall_cnt_d;

    // Clear wins over a same-cycle increment; counters saturate.
    always_comb begin
        grant_cnt_d = grant_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (perf_clr) begin
            grant_cnt_d = '0;
            stall_cnt_d = '0;
        end else begin
            if (complete && grant_cnt_q[owner_q] != 32'hFFFF_FFFF)
                grant_cnt_d[owner_q] = grant_cnt_q[owner_q] + 32'd1;
            if (state_q == ISSUE && stall && stall_cnt_q != 32'hFFFF_FFFF)
                stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign grant_cnt = grant_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed bench for cache_req_arbiter (NUM_REQ=4): cycle vector table plus
// hand-written stall, rotation, async-reset and perf-counter sequences.
module tb_cache_req_arbiter;
    import cache_pkg::*;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [31:0]       req_addr  [N];
    lsu_ops            req_op    [N];
    logic [31:0]       req_wdata [N];
    logic [N-1:0]      req_ready;
    logic [N-1:0]      rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              busy;
    logic [31:0]       address;
    lsu_ops            lsu_operator;
    logic [31:0]       write_data;
    logic              mem_enable;
    logic              stall;
    logic [31:0]       read_data;
`ifdef CACHE_REQ_ARBITER_PERF_EN
    logic              perf_clr;
    logic [N-1:0][31:0] grant_cnt;
    logic [31:0]       stall_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cache_req_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(32), .DATA_WIDTH(32)) u_dut (
        .clk          (clk),
        .rst          (rst),
`ifdef CACHE_REQ_ARBITER_PERF_EN
        .perf_clr     (perf_clr),
        .grant_cnt    (grant_cnt),
        .stall_cnt    (stall_cnt),
`endif
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_op       (req_op),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .busy         (busy),
        .address      (address),
        .lsu_operator (lsu_operator),
        .write_data   (write_data),
        .mem_enable   (mem_enable),
        .stall        (stall),
        .read_data    (read_data)
    );

    typedef struct {
        logic [N-1:0] valid;
        logic         stl;
        logic [31:0]  rdata;
        logic [N-1:0] e_ready;
        logic         e_men;
        logic [N-1:0] e_rsp;
        logic [31:0]  e_addr;
        logic [31:0]  e_rdata;
    } vec_t;

    vec_t vt [23];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One full transaction; returns in the DONE cycle.
    task automatic txn(input logic [N-1:0] v, input logic [N-1:0] e, input int stalls,
                       input string nm);
        @(negedge clk);
        req_valid = v;
        stall = 1'b0;
        #1 chk({nm, "_ready"}, 64'(req_ready), 64'(e));
        @(negedge clk);
        req_valid = '0;
        for (int i = 0; i < stalls; i++) begin
            stall = 1'b1;
            #1 chk({nm, "_men_stall"}, 64'(mem_enable), 64'd1);
            @(negedge clk);
        end
        stall = 1'b0;
        #1 chk({nm, "_men"}, 64'(mem_enable), 64'd1);
        @(negedge clk);
        #1 chk({nm, "_rsp"}, 64'(rsp_valid), 64'(e));
    endtask

    initial begin
        //        valid    stl rdata          rdy      men rsp      addr           rdata
        vt[0]  = '{4'b0000, 0, 32'h0,        4'b0000, 0, 4'b0000, 32'h0,        32'h0};
        vt[1]  = '{4'b0001, 0, 32'h0,        4'b0001, 0, 4'b0000, 32'h0,        32'h0};
        vt[2]  = '{4'b0000, 0, 32'hCAFE0001, 4'b0000, 1, 4'b0000, 32'h40,       32'h0};
        vt[3]  = '{4'b0000, 0, 32'h0,        4'b0000, 0, 4'b0001, 32'h40,       32'hCAFE0001};
        vt[4]  = '{4'b0000, 1, 32'h0,        4'b0000, 0, 4'b0000, 32'h40,       32'h0};
        vt[5]  = '{4'b1111, 0, 32'h0,        4'b0010, 0, 4'b0000, 32'h40,       32'h0};
        vt[6]  = '{4'b1111, 0, 32'h11,       4'b0000, 1, 4'b0000, 32'h1000,     32'h0};
        vt[7]  = '{4'b1111, 0, 32'h0,        4'b0000, 0, 4'b0010, 32'h1000,     32'h11};
        vt[8]  = '{4'b1111, 0, 32'h0,        4'b0100, 0, 4'b0000, 32'h1000,     32'h0};
        vt[9]  = '{4'b1111, 0, 32'h22,       4'b0000, 1, 4'b0000, 32'h2000,     32'h0};
        vt[10] = '{4'b1111, 0, 32'h0,        4'b0000, 0, 4'b0100, 32'h2000,     32'h22};
        vt[11] = '{4'b1111, 0, 32'h0,        4'b1000, 0, 4'b0000, 32'h2000,     32'h0};
        vt[12] = '{4'b1111, 0, 32'h33,       4'b0000, 1, 4'b0000, 32'h3000,     32'h0};
        vt[13] = '{4'b1111, 0, 32'h0,        4'b0000, 0, 4'b1000, 32'h3000,     32'h33};
        vt[14] = '{4'b1111, 0, 32'h0,        4'b0001, 0, 4'b0000, 32'h3000,     32'h0};
        vt[15] = '{4'b1111, 0, 32'h44,       4'b0000, 1, 4'b0000, 32'h40,       32'h0};
        vt[16] = '{4'b1111, 0, 32'h0,        4'b0000, 0, 4'b0001, 32'h40,       32'h44};
        vt[17] = '{4'b0011, 0, 32'h0,        4'b0010, 0, 4'b0000, 32'h40,       32'h0};
        vt[18] = '{4'b0011, 0, 32'h55,       4'b0000, 1, 4'b0000, 32'h1000,     32'h0};
        vt[19] = '{4'b0011, 0, 32'h0,        4'b0000, 0, 4'b0010, 32'h1000,     32'h55};
        vt[20] = '{4'b0011, 0, 32'h0,        4'b0001, 0, 4'b0000, 32'h1000,     32'h0};
        vt[21] = '{4'b0011, 0, 32'h66,       4'b0000, 1, 4'b0000, 32'h40,       32'h0};
        vt[22] = '{4'b0011, 0, 32'h0,        4'b0000, 0, 4'b0001, 32'h40,       32'h66};

        req_addr[0] = 32'h0000_0040;
        req_addr[1] = 32'h0000_1000;
        req_addr[2] = 32'h0000_2000;
        req_addr[3] = 32'h0000_3000;
        req_op[0] = LSU_LW;
        req_op[1] = LSU_SW;
        req_op[2] = LSU_LW;
        req_op[3] = LSU_LBU;
        req_wdata[0] = 32'h0;
        req_wdata[1] = 32'hDEAD_BEEF;
        req_wdata[2] = 32'h2;
        req_wdata[3] = 32'h3;
        req_valid = '0;
        stall = 1'b0;
        read_data = '0;
`ifdef CACHE_REQ_ARBITER_PERF_EN
        perf_clr = 1'b0;
`endif
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_men", 64'(mem_enable), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_op", 64'(lsu_operator), 64'(LSU_LB));
        rst = 1'b1;

        for (int k = 0; k < 23; k++) begin
            @(negedge clk);
            req_valid = vt[k].valid;
            stall = vt[k].stl;
            read_data = vt[k].rdata;
            #1;
            chk($sformatf("v%0d_ready", k), 64'(req_ready), 64'(vt[k].e_ready));
            chk($sformatf("v%0d_men", k), 64'(mem_enable), 64'(vt[k].e_men));
            chk($sformatf("v%0d_rsp", k), 64'(rsp_valid), 64'(vt[k].e_rsp));
            chk($sformatf("v%0d_addr", k), 64'(address), 64'(vt[k].e_addr));
            if (vt[k].e_rsp != '0)
                chk($sformatf("v%0d_rdata", k), 64'(rsp_rdata), 64'(vt[k].e_rdata));
        end

        // Miss hold: requester 1 store, 10 stall cycles, requester 0 waiting.
        @(negedge clk);
        req_valid = 4'b0010;
        stall = 1'b0;
        #1 chk("miss_grant", 64'(req_ready), 64'b0010);
        @(negedge clk);
        req_valid = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            stall = 1'b1;
            #1;
            chk($sformatf("miss_men%0d", i), 64'(mem_enable), 64'd1);
            chk($sformatf("miss_busy%0d", i), 64'(busy), 64'd1);
            chk($sformatf("miss_addr%0d", i), 64'(address), 64'h1000);
            chk($sformatf("miss_wd%0d", i), 64'(write_data), 64'hDEAD_BEEF);
            chk($sformatf("miss_op%0d", i), 64'(lsu_operator), 64'(LSU_SW));
            chk($sformatf("miss_rdy%0d", i), 64'(req_ready), 64'd0);
            chk($sformatf("miss_rsp%0d", i), 64'(rsp_valid), 64'd0);
            @(negedge clk);
        end
        stall = 1'b0;
        #1 chk("miss_men_last", 64'(mem_enable), 64'd1);
        @(negedge clk);
        stall = 1'b1;
        #1;
        chk("miss_rsp", 64'(rsp_valid), 64'b0010);
        chk("miss_men_done", 64'(mem_enable), 64'd0);
        chk("miss_rdy_done", 64'(req_ready), 64'd0);
        @(negedge clk);
        #1 chk("miss_next", 64'(req_ready), 64'b0001);
        @(negedge clk);
        req_valid = '0;
        stall = 1'b0;
        @(negedge clk);
        #1 chk("miss_tail_rsp", 64'(rsp_valid), 64'b0001);

        // Pointer is now 1; grant 2 moves it to 3, then 0 and 2 compete.
        txn(4'b0100, 4'b0100, 0, "ptr_set");
        txn(4'b0101, 4'b0001, 1, "rot_a");
        txn(4'b0101, 4'b0100, 0, "rot_b");

        // Async reset mid-stall (pointer is 3 before it).
        @(negedge clk);
        req_valid = 4'b0010;
        #1 chk("ar_grant", 64'(req_ready), 64'b0010);
        @(negedge clk);
        req_valid = '0;
        stall = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("ar_men", 64'(mem_enable), 64'd0);
        chk("ar_busy", 64'(busy), 64'd0);
        chk("ar_addr", 64'(address), 64'd0);
        chk("ar_wd", 64'(write_data), 64'd0);
        chk("ar_rdata", 64'(rsp_rdata), 64'd0);
        chk("ar_op", 64'(lsu_operator), 64'(LSU_LB));
        chk("ar_rsp", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk($sformatf("ar_norsp%0d", i), 64'(rsp_valid), 64'd0);
        end
        req_valid = 4'b1111;
        #1 chk("ar_first", 64'(req_ready), 64'b0001);
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);

`ifdef CACHE_REQ_ARBITER_PERF_EN
        perf_clr = 1'b1;
        @(negedge clk);
        perf_clr = 1'b0;
        for (int i = 0; i < 3; i++) txn(4'b0001, 4'b0001, 2, "perf_tx");
        @(negedge clk);
        #1;
        chk("perf_grant0", 64'(grant_cnt[0]), 64'd3);
        chk("perf_grant1", 64'(grant_cnt[1]), 64'd0);
        chk("perf_stall", 64'(stall_cnt), 64'd6);
        perf_clr = 1'b1;
        @(negedge clk);
        perf_clr = 1'b0;
        #1;
        chk("perf_clr_g", 64'(grant_cnt[0]), 64'd0);
        chk("perf_clr_s", 64'(stall_cnt), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cache_req_arbiter.md
Name: cache_req_arbiter

Overview:
- Round-robin arbiter that shares the single cache_level_top request port between NUM_REQ requesters (e.g. fetch, LSU, debug).
- Accepts one request at a time and registers it.
- Holds mem_enable and the payload stable until the cache drops stall, then returns read_data to the winning requester.
- Sits between the requester fabric and cache_level_top; it is the only driver of the cache's address, lsu_operator, write_data and mem_enable.

Parameters:
- NUM_REQ, 2: number of requesters; legal range 2..4.
- ADDR_WIDTH, 32: request address width.
- DATA_WIDTH, cache_pkg::DATA_WIDTH: read data width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_addr  in  NUM_REQ x ADDR_WIDTH  per-requester address.
- req_op  in  NUM_REQ x lsu_ops  per-requester operation (cache_pkg::lsu_ops).
- req_wdata  in  NUM_REQ x 32  per-requester store data.
- req_ready  out  NUM_REQ  one-hot; request accepted this cycle.
- rsp_valid  out  NUM_REQ  one-hot, 1-cycle pulse; response available.
- rsp_rdata  out  DATA_WIDTH  response data, shared bus, qualified by rsp_valid.
- busy  out  1  transaction in flight.
- address  out  ADDR_WIDTH  to cache.
- lsu_operator  out  lsu_ops  to cache.
- write_data  out  32  to cache.
- mem_enable  out  1  to cache.
- stall  in  1  from cache.
- read_data  in  DATA_WIDTH  from cache.

Behaviour:
- Reset (rst=0, async):
  - State is IDLE; rr_ptr=0.
  - req_ready, rsp_valid, mem_enable and busy are 0.
  - address, write_data and rsp_rdata are 0; lsu_operator is the first lsu_ops enumerator.
- Reset mid-transaction abandons the transaction; no rsp_valid is issued for it.
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - Winner is the first valid requester at or after rr_ptr, scanning upward modulo NUM_REQ.
  - req_ready[winner]=1 combinationally, only in IDLE.
  - Payload is registered into address/lsu_operator/write_data, owner is stored, and the FSM moves to ISSUE.
  - No valid requester means stay in IDLE.
- ISSUE:
  - mem_enable=1 and busy=1; cache outputs are held stable.
  - A transaction completes on the first ISSUE cycle with stall=0. That cycle read_data is captured into rsp_rdata, rr_ptr becomes (owner+1) mod NUM_REQ, and the FSM moves to DONE.
  - stall=1 means stay in ISSUE for an unbounded time; req_ready stays 0 to all requesters.
- DONE:
  - rsp_valid[owner]=1 for exactly one cycle; mem_enable=0.
  - FSM returns to IDLE.
  - rsp_rdata holds its value until the next completion.
- Latency: request accepted at cycle N → mem_enable from N+1. On a cache hit (stall=0 at N+1), rsp_valid is at N+2. Each stall cycle adds one cycle.
- Throughput: at most one transaction per 3 cycles.
- Requester rules: payload must be held stable while req_valid=1 and req_ready=0. Dropping req_valid before ready is legal; that requester is simply not granted.
- Stores also produce rsp_valid; rsp_rdata content is don't-care for stores.
- Requester i asserting req_valid in the same cycle as its own rsp_valid is legal; it is arbitrated normally in the following IDLE cycle.
- Stall arriving while in IDLE or DONE is ignored.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0,...

Optional Feature:
- Macro: CACHE_REQ_ARBITER_PERF_EN.
- When defined, the block adds:
  - output grant_cnt, NUM_REQ x 32: per-requester completed-transaction counter.
  - output stall_cnt, 32: counts ISSUE cycles with stall=1.
  - input perf_clr, 1: synchronous clear; has priority over increments in the same cycle.
- All counters reset to 0, saturate at 32'hFFFF_FFFF and never wrap.
- When undefined, none of these ports or registers exist; arbitration behaviour is identical.

Test Plan:
1. Single read, hit: req_valid=01, req_addr[0]=32'h0000_0040, op=read, stall=0. Expect req_ready[0] at N, mem_enable at N+1 with address 32'h40, rsp_valid=01 at N+2 with rsp_rdata=read_data.
2. Miss hold: requester 1 store to 32'h0000_1000 with wdata 32'hDEAD_BEEF, stall=1 for 10 cycles. Expect mem_enable high for 11 cycles, address/write_data stable, req_ready=0 throughout, rsp_valid[1] one cycle after stall falls.
3. Round-robin, NUM_REQ=2: both requesters valid continuously for 4 transactions. Expect grant order 0,1,0,1 and no requester granted twice in a row.
4. Rotation from non-zero pointer, NUM_REQ=4: rr_ptr=3, requesters 0 and 2 valid. Expect grant 0, then 2.
5. Async reset: rst low in ISSUE mid-stall. Expect all outputs at reset values immediately without a clock edge, no rsp_valid after release, and the next grant starting from requester 0.
6. Perf counters (CACHE_REQ_ARBITER_PERF_EN): 3 grants to requester 0 with 2 stall cycles each. Expect grant_cnt[0]=3 and stall_cnt=6; perf_clr pulse gives 0 the next cycle.
